// File: rtl/riscv_core_fetch_pc_t.sv
// Fetch PC owner: holds r_pc, issues one fetch at a time and buffers
// the returned instruction for decode, with reset/redirect overrides.
module riscv_core_fetch_pc_t #(
  parameter logic [31:0] START_ADDRESS = 32'h00001000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] reset_D,
  input  logic        reset_WE,
  input  logic [31:0] redir_D,
  input  logic        redir_WE,
  output logic        if_req_VLD,
  output logic [31:0] if_req_ADDR,
  input  logic        if_req_RDY,
  input  logic        if_rsp_VLD,
  input  logic [31:0] if_rsp_DATA,
  output logic        inst_VLD,
  output logic [31:0] inst_DATA,
  output logic [31:0] inst_PC,
  input  logic        inst_RDY,
  output logic [31:0] r_pc_Q
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, data_nxt, ipc_nxt;
  logic        wr_en;
  logic [31:0] wr_val;

  // Reset write wins over redirect; every PC write is word aligned.
  assign wr_en  = reset_WE | redir_WE;
  assign wr_val = (reset_WE ? reset_D : redir_D) & 32'hFFFF_FFFC;

  assign if_req_VLD  = (state == REQ);
  assign inst_VLD    = (state == HOLD);
  assign if_req_ADDR = r_pc_Q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = r_pc_Q;
    data_nxt  = inst_DATA;
    ipc_nxt   = inst_PC;
    case (state)
      BOOT: begin
        if (reset_WE) begin
          pc_nxt    = reset_D & 32'hFFFF_FFFC;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (wr_en) begin
          pc_nxt    = wr_val;
          state_nxt = if_req_RDY ? DROP : REQ;
        end else if (if_req_RDY) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wr_en) begin
          pc_nxt    = wr_val;
          state_nxt = if_rsp_VLD ? REQ : DROP;
        end else if (if_rsp_VLD) begin
          data_nxt  = if_rsp_DATA;
          ipc_nxt   = r_pc_Q;
          pc_nxt    = r_pc_Q + 32'd4;
          state_nxt = HOLD;
        end
      end
      DROP: begin
        if (wr_en) pc_nxt = wr_val;
        if (if_rsp_VLD) state_nxt = REQ;
      end
      HOLD: begin
        if (wr_en) begin
          pc_nxt    = wr_val;
          state_nxt = REQ;
        end else if (inst_RDY) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= BOOT;
      r_pc_Q    <= START_ADDRESS;
      inst_DATA <= 32'h0;
      inst_PC   <= 32'h0;
    end else begin
      state     <= state_nxt;
      r_pc_Q    <= pc_nxt;
      inst_DATA <= data_nxt;
      inst_PC   <= ipc_nxt;
    end
  end

endmodule

// File: tb/tb_riscv_core_fetch_pc_t.sv
// Self-checking bench for riscv_core_fetch_pc_t: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_riscv_core_fetch_pc_t;

  localparam logic [31:0] START = 32'h00001000;

  logic        CLK = 1'b0;
  logic        RST, reset_WE, redir_WE, if_req_RDY, if_rsp_VLD, inst_RDY;
  logic [31:0] reset_D, redir_D, if_rsp_DATA;
  logic        if_req_VLD, inst_VLD;
  logic [31:0] if_req_ADDR, inst_DATA, inst_PC, r_pc_Q;

  riscv_core_fetch_pc_t #(.START_ADDRESS(START)) dut (
    .CLK(CLK), .RST(RST),
    .reset_D(reset_D), .reset_WE(reset_WE),
    .redir_D(redir_D), .redir_WE(redir_WE),
    .if_req_VLD(if_req_VLD), .if_req_ADDR(if_req_ADDR), .if_req_RDY(if_req_RDY),
    .if_rsp_VLD(if_rsp_VLD), .if_rsp_DATA(if_rsp_DATA),
    .inst_VLD(inst_VLD), .inst_DATA(inst_DATA), .inst_PC(inst_PC),
    .inst_RDY(inst_RDY), .r_pc_Q(r_pc_Q)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: tracks whether the core has been started, whether a
  // fetch is in flight (and whether its answer is already unwanted), and
  // whether an instruction is sitting in the buffer.
  bit          m_started, m_inflight, m_unwanted, m_buffered;
  logic [31:0] m_pc, m_data, m_ipc;

  function automatic bit m_requesting();
    return m_started && !m_inflight && !m_buffered;
  endfunction

  task automatic model_step();
    logic [31:0] target;
    bit          write;
    write  = reset_WE || redir_WE;
    target = {(reset_WE ? reset_D[31:2] : redir_D[31:2]), 2'b00};
    if (RST) begin
      m_started = 0; m_inflight = 0; m_unwanted = 0; m_buffered = 0;
      m_pc = START; m_data = 0; m_ipc = 0;
    end else if (!m_started) begin
      if (reset_WE) begin
        m_pc = {reset_D[31:2], 2'b00};
        m_started = 1;
      end
    end else if (m_buffered) begin
      if (write) begin
        m_pc = target; m_buffered = 0;
      end else if (inst_RDY) m_buffered = 0;
    end else if (!m_inflight) begin
      if (if_req_RDY) begin
        m_inflight = 1; m_unwanted = write;
      end
      if (write) m_pc = target;
    end else begin
      if (if_rsp_VLD) begin
        m_inflight = 0;
        if (write) m_pc = target;
        else if (!m_unwanted) begin
          m_data = if_rsp_DATA; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_buffered = 1;
        end
      end else if (write) begin
        m_pc = target; m_unwanted = 1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic rwe, input logic [31:0] rd,
                      input logic xwe, input logic [31:0] xd, input logic rdy,
                      input logic rsp, input logic [31:0] rdat, input logic irdy);
    RST = rst; reset_WE = rwe; reset_D = rd; redir_WE = xwe; redir_D = xd;
    if_req_RDY = rdy; if_rsp_VLD = rsp; if_rsp_DATA = rdat; inst_RDY = irdy;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check("if_req_VLD", {31'b0, if_req_VLD}, {31'b0, m_requesting()});
    check("inst_VLD", {31'b0, inst_VLD}, {31'b0, m_buffered});
    check("r_pc_Q", r_pc_Q, m_pc);
    check("inst_DATA", inst_DATA, m_data);
    check("inst_PC", inst_PC, m_ipc);
    if (m_requesting()) check("if_req_ADDR", if_req_ADDR, m_pc);
  endtask

  task automatic idle(input logic rdy, input logic rsp, input logic irdy);
    step(0, 0, 0, 0, 0, rdy, rsp, 32'hBAD0_BAD0, irdy);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFC;
      1: return 32'hFFFF_FFF8;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RST = 0; reset_WE = 0; redir_WE = 0; if_req_RDY = 0; if_rsp_VLD = 0; inst_RDY = 0;
    reset_D = 0; redir_D = 0; if_rsp_DATA = 0;
    m_started = 0; m_inflight = 0; m_unwanted = 0; m_buffered = 0;
    m_pc = START; m_data = 0; m_ipc = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", r_pc_Q, 32'h00001000);
    check("rst_inst_vld", {31'b0, inst_VLD}, 32'd0);
    check("rst_req_vld", {31'b0, if_req_VLD}, 32'd0);
    check("rst_inst_data", inst_DATA, 32'd0);

    // Redirect ignored while booting
    step(0, 0, 0, 1, 32'h0000_5000, 1, 1, 0, 1);
    check("boot_redir_ignored", r_pc_Q, 32'h00001000);

    // Start and first fetch
    step(0, 1, 32'h00001000, 0, 0, 0, 0, 0, 0);
    check("start_req_vld", {31'b0, if_req_VLD}, 32'd1);
    check("start_req_addr", if_req_ADDR, 32'h00001000);
    idle(1, 0, 0);
    check("wait_req_vld", {31'b0, if_req_VLD}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h00000013, 0);
    check("hold_vld", {31'b0, inst_VLD}, 32'd1);
    check("hold_pc", inst_PC, 32'h00001000);
    check("hold_data", inst_DATA, 32'h00000013);
    check("hold_rpc", r_pc_Q, 32'h00001004);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      idle(0, 1, 0);
      check("stall_vld", {31'b0, inst_VLD}, 32'd1);
      check("stall_data", inst_DATA, 32'h00000013);
      check("stall_pc", inst_PC, 32'h00001000);
      check("stall_req", {31'b0, if_req_VLD}, 32'd0);
    end
    idle(0, 0, 1);
    check("next_addr", if_req_ADDR, 32'h00001004);

    // Redirect during WAIT discards the response
    idle(1, 0, 0);
    step(0, 0, 0, 1, 32'h00002002, 0, 0, 0, 0);
    check("drop_rpc", r_pc_Q, 32'h00002000);
    step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    check("drop_no_inst", {31'b0, inst_VLD}, 32'd0);
    check("redir_addr", if_req_ADDR, 32'h00002000);

    // Simultaneous writes: reset write wins
    step(0, 1, 32'h1000, 1, 32'h3000, 0, 0, 0, 0);
    check("prio_rpc", r_pc_Q, 32'h00001000);

    // Wrap-around increment
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0055, 0);
    check("wrap_inst_pc", inst_PC, 32'hFFFF_FFFC);
    check("wrap_rpc", r_pc_Q, 32'h00000000);

    // RST mid-WAIT, then a late response
    idle(0, 0, 1);
    idle(1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1, 1);
      check("late_rsp_no_inst", {31'b0, inst_VLD}, 32'd0);
      check("late_rsp_no_req", {31'b0, if_req_VLD}, 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rwe, xwe;
      rwe = ($urandom_range(0, 39) == 0) || (!m_started && $urandom_range(0, 3) == 0);
      xwe = ($urandom_range(0, 19) == 0);
      step(($urandom_range(0, 299) == 0), rwe, rand_addr(), xwe, rand_addr(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1), $urandom,
           ($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
